// File: rtl/simd_alu_pipe.sv
// Pipelined packed-integer ALU: stage 1 registers the operation, stage 2 computes
// per-lane wrap/saturating arithmetic, shuffle, AND and compare, and registers the result.

module simd_alu_lane #(
    parameter int LANE_W = 16,
    parameter int NLANES = 4,
    parameter int SEL_W  = 2,
    parameter int DATA_W = 64
) (
    input  logic [2:0]        i_op,
    input  logic [LANE_W-1:0] i_a,
    input  logic [LANE_W-1:0] i_b,
    input  logic [SEL_W-1:0]  i_sel,
    input  logic [DATA_W-1:0] i_b_all,
    output logic [LANE_W-1:0] o_res,
    output logic              o_sat
);
    localparam logic [LANE_W-1:0] SMAX = {1'b0, {(LANE_W-1){1'b1}}};
    localparam logic [LANE_W-1:0] SMIN = {1'b1, {(LANE_W-1){1'b0}}};

    logic [LANE_W:0]   w_uadd, w_sadd, w_ssub;
    logic              w_sadd_ovf, w_ssub_ovf;
    logic [LANE_W-1:0] w_shuf;

    // One extra bit holds the true carry/sign so clamping never loses information.
    assign w_uadd     = {1'b0, i_a} + {1'b0, i_b};
    assign w_sadd     = {i_a[LANE_W-1], i_a} + {i_b[LANE_W-1], i_b};
    assign w_ssub     = {i_a[LANE_W-1], i_a} - {i_b[LANE_W-1], i_b};
    assign w_sadd_ovf = w_sadd[LANE_W] ^ w_sadd[LANE_W-1];
    assign w_ssub_ovf = w_ssub[LANE_W] ^ w_ssub[LANE_W-1];

    // Out-of-range selectors (non power-of-two lane counts) yield zero.
    always_comb begin
        w_shuf = '0;
        for (int j = 0; j < NLANES; j++) begin
            if (i_sel == SEL_W'(j))
                w_shuf = i_b_all[j*LANE_W +: LANE_W];
        end
    end

    always_comb begin
        o_res = '0;
        o_sat = 1'b0;
        case (i_op)
            3'd0: o_res = w_uadd[LANE_W-1:0];
            3'd1: o_res = w_ssub[LANE_W-1:0];
            3'd2: begin
                o_sat = w_sadd_ovf;
                o_res = w_sadd_ovf ? (w_sadd[LANE_W] ? SMIN : SMAX) : w_sadd[LANE_W-1:0];
            end
            3'd3: begin
                o_sat = w_uadd[LANE_W];
                o_res = w_uadd[LANE_W] ? '1 : w_uadd[LANE_W-1:0];
            end
            3'd4: begin
                o_sat = w_ssub_ovf;
                o_res = w_ssub_ovf ? (w_ssub[LANE_W] ? SMIN : SMAX) : w_ssub[LANE_W-1:0];
            end
            3'd5: o_res = w_shuf;
            3'd6: o_res = i_a & i_b;
            default: o_res = (i_a == i_b) ? '1 : '0;
        endcase
    end
endmodule

module simd_alu_pipe #(
    parameter int DATA_W = 64,
    parameter int LANE_W = 16
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] mm_a,
    input  logic [DATA_W-1:0] mm_b,
    input  logic [31:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic [DATA_W/LANE_W-1:0] sat_mask
);
    localparam int NLANES = DATA_W / LANE_W;
    localparam int SEL_W  = $clog2(NLANES);
    localparam int IMM_W  = NLANES * SEL_W;

    logic                            r_s1_valid, r_s2_valid;
    logic [2:0]                      r_s1_op;
    logic [DATA_W-1:0]               r_s1_a, r_s1_b;
    logic [IMM_W-1:0]                r_s1_imm;
    logic [NLANES-1:0][LANE_W-1:0]   r_result;
    logic [NLANES-1:0]               r_sat;
    logic [NLANES-1:0][LANE_W-1:0]   w_lane_res;
    logic [NLANES-1:0]               w_lane_sat;
    logic                            w_s2_adv, w_accept;
    logic                            w_unused_imm;

    assign w_unused_imm = ^imm[31:IMM_W];

    assign w_s2_adv = r_s1_valid && (!r_s2_valid || out_ready);
    assign in_ready = !flush && (!r_s1_valid || w_s2_adv);
    assign w_accept = in_valid && in_ready;

    assign out_valid = r_s2_valid;
    assign result    = r_result;
    assign sat_mask  = r_sat;

    for (genvar g = 0; g < NLANES; g++) begin : g_lane
        simd_alu_lane #(
            .LANE_W(LANE_W), .NLANES(NLANES), .SEL_W(SEL_W), .DATA_W(DATA_W)
        ) u_lane (
            .i_op    (r_s1_op),
            .i_a     (r_s1_a[g*LANE_W +: LANE_W]),
            .i_b     (r_s1_b[g*LANE_W +: LANE_W]),
            .i_sel   (r_s1_imm[g*SEL_W +: SEL_W]),
            .i_b_all (r_s1_b),
            .o_res   (w_lane_res[g]),
            .o_sat   (w_lane_sat[g])
        );
    end

    // Data registers only load on accept/advance, so idle-cycle X never reaches them.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s1_op    <= '0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_imm   <= '0;
            r_result   <= '0;
            r_sat      <= '0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_s1_valid <= 1'b1;
                r_s1_op    <= op;
                r_s1_a     <= mm_a;
                r_s1_b     <= mm_b;
                r_s1_imm   <= imm[IMM_W-1:0];
            end else if (w_s2_adv) begin
                r_s1_valid <= 1'b0;
            end
            if (w_s2_adv) begin
                r_s2_valid <= 1'b1;
                r_result   <= w_lane_res;
                r_sat      <= w_lane_sat;
            end else if (r_s2_valid && out_ready) begin
                r_s2_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_simd_alu_pipe.sv
// Directed bench for simd_alu_pipe: a 16-bit-lane instance with an in-order
// scoreboard on its output, plus an 8-bit-lane instance for byte-lane vectors.

module tb_simd_alu_pipe;
    typedef struct packed {
        logic [63:0] res;
        logic [3:0]  sat;
    } exp_t;

    logic        CLK, CLR;
    logic        flush, in_valid, in_ready, out_valid, out_ready;
    logic [2:0]  op;
    logic [63:0] mm_a, mm_b, result;
    logic [31:0] imm;
    logic [3:0]  sat_mask;

    logic        flush8, in_valid8, in_ready8, out_valid8, out_ready8;
    logic [2:0]  op8;
    logic [63:0] a8, b8, result8;
    logic [31:0] imm8;
    logic [7:0]  sat8;

    int   n_tot, n_bad, cyc;
    exp_t exp_q[$];
    int   pop_cyc[$];

    simd_alu_pipe u_dut16 (
        .CLK(CLK), .CLR(CLR), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .mm_a(mm_a), .mm_b(mm_b), .imm(imm), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .sat_mask(sat_mask)
    );

    simd_alu_pipe #(.DATA_W(64), .LANE_W(8)) u_dut8 (
        .CLK(CLK), .CLR(CLR), .flush(flush8), .in_valid(in_valid8), .in_ready(in_ready8),
        .op(op8), .mm_a(a8), .mm_b(b8), .imm(imm8), .out_valid(out_valid8),
        .out_ready(out_ready8), .result(result8), .sat_mask(sat8)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // In-order scoreboard on the 16-bit instance.
    always @(negedge CLK) begin
        if (CLR && out_valid && out_ready) begin
            pop_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("unexpected_out", 64'(exp_q.size()), 64'd1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_res", result, e.res);
                chk("out_sat", 64'(sat_mask), 64'(e.sat));
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b,
                        input logic [31:0] im, input logic [63:0] er, input logic [3:0] es);
        in_valid = 1'b1; op = o; mm_a = a; mm_b = b; imm = im;
        for (int k = 0; k < 50; k++) begin
            @(negedge CLK);
            if (in_ready) begin
                exp_q.push_back('{res: er, sat: es});
                @(posedge CLK); #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge CLK); #1;
        end
        chk("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int k = 0; k < 50; k++) begin
            if (exp_q.size() == 0) return;
            @(posedge CLK); #2;
        end
        chk(tag, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic run8(input string tag, input logic [2:0] o, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] er, input logic [7:0] es);
        in_valid8 = 1'b1; op8 = o; a8 = a; b8 = b;
        @(negedge CLK);
        chk({tag, "_rdy"}, 64'(in_ready8), 64'd1);
        @(posedge CLK); #1;
        in_valid8 = 1'b0;
        @(negedge CLK);
        chk({tag, "_v0"}, 64'(out_valid8), 64'd0);
        @(negedge CLK);
        chk({tag, "_v1"}, 64'(out_valid8), 64'd1);
        chk({tag, "_res"}, result8, er);
        chk({tag, "_sat"}, 64'(sat8), 64'(es));
        @(posedge CLK); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", n_tot, n_bad);
        $fatal(1);
    end

    initial begin
        n_tot = 0; n_bad = 0; cyc = 0;
        CLR = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = '0; mm_a = '0; mm_b = '0; imm = '0;
        flush8 = 1'b0; in_valid8 = 1'b0; out_ready8 = 1'b1; op8 = '0; a8 = '0; b8 = '0; imm8 = '0;
        #2 CLR = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst_ovalid", 64'(out_valid), 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_sat", 64'(sat_mask), 64'd0);
        CLR = 1'b1;
        @(negedge CLK);
        chk("rst_inready", 64'(in_ready), 64'd1);
        @(posedge CLK); #1;

        // Signed saturating add with latency check.
        send(3'd2, 64'h0003_8000_7FFF_0001, 64'h0004_FFFF_0001_0001, 32'h0,
             64'h0007_8000_7FFF_0002, 4'b0110);
        chk("lat_edge1", 64'(out_valid), 64'd0);
        @(posedge CLK); #1;
        chk("lat_edge2", 64'(out_valid), 64'd1);
        wait_drain("drain_op2");

        send(3'd5, 64'h0, 64'h4444_3333_2222_1111, 32'h0000_001B, 64'h1111_2222_3333_4444, 4'b0000);
        send(3'd5, 64'h0, 64'h4444_3333_2222_1111, 32'hFFFF_FFE4, 64'h4444_3333_2222_1111, 4'b0000);
        send(3'd0, 64'h0001_7FFF_FFFF_1234, 64'h0001_0001_0001_1111, 32'h0, 64'h0002_8000_0000_2345, 4'b0000);
        send(3'd1, 64'h7FFF_0005_8000_0001, 64'hFFFF_0003_0001_0002, 32'h0, 64'h8000_0002_7FFF_FFFF, 4'b0000);
        send(3'd4, 64'h7FFF_0005_8000_0001, 64'hFFFF_0003_0001_0002, 32'h0, 64'h7FFF_0002_8000_FFFF, 4'b1010);
        send(3'd3, 64'hFFFF_0001_8000_0001, 64'h0001_0001_8000_FFFE, 32'h0, 64'hFFFF_0002_FFFF_FFFF, 4'b1010);
        send(3'd6, 64'hF0F0_FFFF_0000_1234, 64'hFF00_1234_FFFF_00FF, 32'h0, 64'hF000_1234_0000_0034, 4'b0000);
        send(3'd7, 64'h1234_5678_9ABC_DEF0, 64'h1234_0000_9ABC_0001, 32'h0, 64'hFFFF_0000_FFFF_0000, 4'b0000);
        wait_drain("drain_ops");

        // Backpressure: two fill the pipe, the third waits.
        out_ready = 1'b0;
        send(3'd0, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0001, 32'h0, 64'h0000_0000_0000_0002, 4'b0000);
        send(3'd0, 64'h0000_0000_0000_0002, 64'h0000_0000_0000_0001, 32'h0, 64'h0000_0000_0000_0003, 4'b0000);
        in_valid = 1'b1; op = 3'd0; mm_a = 64'h5; mm_b = 64'h1; imm = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            chk("bp_inready", 64'(in_ready), 64'd0);
            chk("bp_ovalid", 64'(out_valid), 64'd1);
            chk("bp_hold_res", result, 64'h2);
        end
        @(posedge CLK); #1;
        pop_cyc.delete();
        out_ready = 1'b1;
        send(3'd0, 64'h5, 64'h1, 32'h0, 64'h6, 4'b0000);
        send(3'd3, 64'hFFFF, 64'h1, 32'h0, 64'hFFFF, 4'b0001);
        wait_drain("drain_bp");
        chk("bp_count", 64'(pop_cyc.size()), 64'd4);
        if (pop_cyc.size() == 4)
            chk("bp_consecutive", 64'(pop_cyc[3] - pop_cyc[0]), 64'd3);

        // Flush with two in flight and a new op offered.
        out_ready = 1'b0;
        send(3'd0, 64'hAAAA, 64'h1, 32'h0, 64'hAAAB, 4'b0000);
        send(3'd0, 64'hBBBB, 64'h1, 32'h0, 64'hBBBC, 4'b0000);
        flush = 1'b1; in_valid = 1'b1; op = 3'd0; mm_a = 64'hCCCC; mm_b = 64'h1;
        @(negedge CLK);
        chk("flush_inready", 64'(in_ready), 64'd0);
        chk("flush_pre_ovalid", 64'(out_valid), 64'd1);
        @(posedge CLK); #1;
        flush = 1'b0; in_valid = 1'b0;
        exp_q.delete();
        chk("flush_ovalid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            chk("flush_quiet", 64'(out_valid), 64'd0);
        end
        @(posedge CLK); #1;
        send(3'd6, 64'hFFFF_0000_FFFF_0F0F, 64'h1234_5678_9ABC_FFFF, 32'h0, 64'h1234_0000_9ABC_0F0F, 4'b0000);
        chk("flush_lat1", 64'(out_valid), 64'd0);
        @(posedge CLK); #1;
        chk("flush_lat2", 64'(out_valid), 64'd1);
        wait_drain("drain_flush");

        // Asynchronous reset mid-stream.
        out_ready = 1'b0;
        send(3'd0, 64'h1111_1111_1111_1111, 64'h1111_1111_1111_1111, 32'h0, 64'h2222_2222_2222_2222, 4'b0000);
        send(3'd3, 64'hFFFF, 64'h2, 32'h0, 64'hFFFF, 4'b0001);
        #2;
        chk("clr_pre_ovalid", 64'(out_valid), 64'd1);
        CLR = 1'b0;
        #1;
        chk("clr_ovalid", 64'(out_valid), 64'd0);
        chk("clr_result", result, 64'd0);
        chk("clr_sat", 64'(sat_mask), 64'd0);
        exp_q.delete();
        @(negedge CLK);
        CLR = 1'b1;
        out_ready = 1'b1;
        @(posedge CLK); #1;
        chk("clr_inready", 64'(in_ready), 64'd1);
        send(3'd2, 64'h7FFF_0001_0001_8000, 64'h7FFF_0001_0002_8000, 32'h0, 64'h7FFF_0002_0003_8000, 4'b1001);
        wait_drain("drain_clr");
        repeat (3) @(posedge CLK);
        #1;

        // Byte lanes.
        run8("b_op0", 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0101_0101_0101_0101, 64'h0, 8'h00);
        run8("b_op3", 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0101_0101_0101_0101, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        run8("b_op7", 3'd7, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
        run8("b_op7ne", 3'd7, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_8900_CDEF, 64'hFFFF_FFFF_FF00_FFFF, 8'h00);
        run8("b_op2", 3'd2, 64'h7F80_0000_0000_0000, 64'h01FF_0000_0000_0000, 64'h7F80_0000_0000_0000, 8'hC0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
